// File: rtl/io_pkg.sv
// Shared types and constants for the switch input port.
package io_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } state_e;

   localparam int unsigned DB_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchronizer followed by a stability-window debouncer.
module debounce_bit
   import io_pkg::*;
#(
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic sw,
   output logic db
);

   localparam int unsigned CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [1:0]    sync_q, sync_d;
   logic          db_q, db_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Count consecutive cycles of disagreement; accept the new level on the last one.
   always_comb begin
      sync_d = {sync_q[0], sw};
      db_d   = db_q;
      cnt_d  = '0;
      if (sync_q[1] != db_q) begin
         if (cnt_q >= CNT_LAST) begin
            db_d  = sync_q[1];
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         db_q   <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= sync_d;
         db_q   <= db_d;
         cnt_q  <= cnt_d;
      end
   end

   assign db = db_q;

endmodule

// File: rtl/switch_in_port.sv
// Debounced board-switch input port: captures the data byte when the handshake switch rises.
module switch_in_port
   import io_pkg::*;
#(
   parameter int unsigned n         = 8,
   parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [n:0] sw,
   output logic [n:0] data_in,
   output logic       strobe
);

   logic [n:0] db;
   state_e     state_q, state_d;
   logic [n:0] data_in_q, data_in_d;
   logic       strobe_q, strobe_d;

   for (genvar i = 0; i < n + 1; i++) begin : g_db
      debounce_bit #(
         .DB_CYCLES(DB_CYCLES)
      ) u_db (
         .clk  (clk),
         .reset(reset),
         .sw   (sw[i]),
         .db   (db[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == IDLE) begin
         if (db[n]) state_d = HELD;
      end else begin
         if (!db[n]) state_d = IDLE;
      end
   end

   // Capture uses the registered db, so a data bit settling on the capture edge is seen at its old value.
   always_comb begin
      data_in_d = data_in_q;
      strobe_d  = 1'b0;
      if (state_q == IDLE && state_d == HELD) begin
         data_in_d = {1'b1, db[n-1:0]};
         strobe_d  = 1'b1;
      end else if (state_q == HELD && state_d == IDLE) begin
         data_in_d[n] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_in_q <= '0;
         strobe_q  <= 1'b0;
      end else begin
         data_in_q <= data_in_d;
         strobe_q  <= strobe_d;
      end
   end

   assign data_in = data_in_q;
   assign strobe  = strobe_q;

endmodule

// File: tb/tb_switch_in_port.sv
// Bench for switch_in_port (n=8, DB_CYCLES=4): directed scenarios plus random switch activity.
module tb_switch_in_port;

   localparam int unsigned N  = 8;
   localparam int unsigned DB = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [N:0] sw;
   logic [N:0] data_in;
   logic       strobe;

   int n_cmp = 0;
   int n_err = 0;
   int strobe_seen = 0;

   switch_in_port #(
      .n(N),
      .DB_CYCLES(DB)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .sw     (sw),
      .data_in(data_in),
      .strobe (strobe)
   );

   always #5 clk = ~clk;

   // Reference model: a bit's debounced level flips once the synchronized switch
   // has disagreed with it on DB consecutive non-reset edges.
   logic [N:0] hist [0:4095];
   logic [N:0] m_db   = '0;
   logic [N:0] m_data = '0;
   logic       m_strobe = 1'b0;
   logic       m_held   = 1'b0;
   int         t        = 0;
   int         last_rst = 0;

   function automatic int idx(input int e);
      return e & 4095;
   endfunction

   always @(posedge clk) begin
      logic [N:0] new_db;
      bit ok;
      int e;
      t = t + 1;
      if (reset) begin
         hist[idx(t)]     = '0;
         hist[idx(t - 1)] = '0;
         last_rst = t;
         m_db     = '0;
         m_held   = 1'b0;
         m_data   = '0;
         m_strobe = 1'b0;
      end else begin
         m_strobe = 1'b0;
         if (!m_held && m_db[N]) begin
            m_held   = 1'b1;
            m_data   = {1'b1, m_db[N-1:0]};
            m_strobe = 1'b1;
         end else if (m_held && !m_db[N]) begin
            m_held    = 1'b0;
            m_data[N] = 1'b0;
         end
         new_db = m_db;
         for (int i = 0; i <= int'(N); i++) begin
            ok = 1'b1;
            for (int k = 0; k < int'(DB); k++) begin
               e = t - k;
               if (e <= last_rst || e < 2) ok = 1'b0;
               else if (hist[idx(e - 2)][i] == m_db[i]) ok = 1'b0;
            end
            if (ok) new_db[i] = ~m_db[i];
         end
         m_db = new_db;
         hist[idx(t)] = sw;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check("data_in", 32'(data_in), 32'(m_data));
      check("strobe", 32'(strobe), 32'(m_strobe));
      if (strobe) strobe_seen++;
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   initial begin
      reset = 1'b1;
      sw    = '0;
      steps(3);
      check("reset_data", 32'(data_in), 32'h0);
      check("reset_strobe", 32'(strobe), 32'h0);
      reset = 1'b0;

      // Quiet switches
      strobe_seen = 0;
      steps(20);
      check("idle_data", 32'(data_in), 32'h0);
      check("idle_no_strobe", 32'(strobe_seen), 32'h0);

      // Capture A5: valid rises exactly 7 edges after the handshake rise
      sw = 9'h0A5;
      steps(10);
      sw[8] = 1'b1;
      steps(6);
      check("latency_before", 32'(data_in[8]), 32'h0);
      step();
      check("capture_a5", 32'(data_in), 32'h1A5);
      check("capture_strobe", 32'(strobe), 32'h1);
      step();
      check("strobe_one_cycle", 32'(strobe), 32'h0);

      // Byte frozen while held, then release
      sw[7:0] = 8'h3C;
      steps(10);
      check("held_frozen", 32'(data_in[7:0]), 32'hA5);
      sw[8] = 1'b0;
      steps(6);
      check("release_before", 32'(data_in[8]), 32'h1);
      step();
      check("release_after", 32'(data_in), 32'h0A5);

      // Short handshake glitch is rejected
      steps(10);
      strobe_seen = 0;
      sw[8] = 1'b1;
      steps(3);
      sw[8] = 1'b0;
      steps(15);
      check("glitch_no_strobe", 32'(strobe_seen), 32'h0);
      check("glitch_valid", 32'(data_in[8]), 32'h0);

      // Reset while held with handshake still high, then re-debounce
      sw = 9'h15A;
      steps(20);
      check("held_5a", 32'(data_in), 32'h15A);
      reset = 1'b1;
      step();
      check("reset_in_held", 32'(data_in), 32'h0);
      reset = 1'b0;
      steps(6);
      check("rearm_before", 32'(data_in[8]), 32'h0);
      step();
      check("rearm_capture", 32'(data_in), 32'h15A);

      // Data bit settling on the capture edge is captured at its old level
      sw = '0;
      steps(20);
      sw[8] = 1'b1;
      step();
      sw[0] = 1'b1;
      steps(5);
      check("cap_pre_edge", 32'(data_in[8]), 32'h0);
      step();
      check("cap_b0_old", 32'(data_in[0]), 32'h0);
      check("cap_valid", 32'(data_in[8]), 32'h1);

      // Data bit and handshake toggled together
      sw = '0;
      steps(20);
      sw[0] = 1'b1;
      sw[8] = 1'b1;
      steps(10);
      sw = '0;
      steps(10);

      // Random switch activity with occasional reset
      repeat (180) begin
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b1;
            steps(int'($urandom_range(1, 2)));
            reset = 1'b0;
         end
         if ($urandom_range(0, 2) == 0) sw[7:0] = 8'($urandom);
         if ($urandom_range(0, 1) == 0) sw[8] = ~sw[8];
         steps(int'($urandom_range(1, 10)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
